eth_tx_framer: RTL and testbench

- Builds complete Ethernet II frames from a byte-wide payload stream and drives the transmit logic side of mac_rgmii: mac_tx_data, mac_tx_valid, mac_tx_sof and mac_tx_eof.
- Each frame is destination MAC, source MAC, EtherType, payload, zero padding to the 60-byte minimum, and a 4-byte FCS.
- mac_rgmii inserts the preamble/SFD; this block supplies everything from the destination address through the FCS.
- The block runs in the mac_gtx_clk domain, one instance per eth channel.

---
 rtl/eth_pkg.sv | 29 ++
 rtl/crc32_d8.sv | 17 +
 rtl/eth_tx_framer.sv | 189 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, the transmit framer state encoding and CRC-32 parameters.
package eth_pkg;

    // state | meaning
    // IDLE  | waiting for the first payload byte; CRC held at its initial value
    // HDR   | emitting destination MAC, source MAC and EtherType
    // PAY   | forwarding payload bytes one per cycle
    // PAD   | emitting zero bytes up to the minimum payload length
    // FCS   | emitting the inverted CRC, low byte first
    // DROP  | discarding input up to tlast with the transmit side idle
    // IFG   | enforced inter-frame gap
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        PAD,
        FCS,
        DROP,
        IFG
    } state_t;

    localparam int ETH_HDR_LEN     = 14;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_FCS_LEN     = 4;

    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte (LSB of the byte enters first).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY) : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: header, payload, zero padding and FCS towards mac_rgmii.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1500,
    parameter int IFG_CYCLES  = 12,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [47:0]      dst_mac,
    input  logic [47:0]      src_mac,
    input  logic [15:0]      ethertype,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [7:0]       mac_tx_data,
    output logic             mac_tx_valid,
    output logic             mac_tx_sof,
    output logic             mac_tx_eof,
    output logic             busy,
    output logic             tx_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] trunc_cnt
);

    localparam int PC_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int TMR_W = 16;

    state_t           state, state_d;
    logic [103:0]     hdr_sr, hdr_sr_d;
    logic [PC_W-1:0]  pay_cnt, pay_cnt_d, pay_inc;
    logic [TMR_W-1:0] tmr, tmr_d;
    logic             trunc, trunc_d;
    logic [31:0]      crc, crc_d, crc_nxt;
    logic             crc_upd;
    logic [7:0]       data_d;
    logic             valid_d, sof_d, eof_d, err_d;
    logic [CNT_W-1:0] frame_cnt_d, trunc_cnt_d;

    assign s_tready = (state == PAY) || (state == DROP);
    assign pay_inc  = pay_cnt + PC_W'(1);

    crc32_d8 u_crc (
        .crc      (crc),
        .data     (data_d),
        .crc_next (crc_nxt)
    );

    always_comb begin
        state_d     = state;
        hdr_sr_d    = hdr_sr;
        pay_cnt_d   = pay_cnt;
        tmr_d       = tmr;
        trunc_d     = trunc;
        crc_d       = crc;
        crc_upd     = 1'b0;
        data_d      = 8'h00;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt;
        trunc_cnt_d = trunc_cnt;

        case (state)
            IDLE: begin
                crc_d = CRC32_INIT;
                if (s_tvalid) begin
                    // First header byte goes out on the start edge; the rest is snapshotted here
                    state_d   = HDR;
                    hdr_sr_d  = {dst_mac[39:0], src_mac, ethertype};
                    data_d    = dst_mac[47:40];
                    valid_d   = 1'b1;
                    sof_d     = 1'b1;
                    crc_upd   = 1'b1;
                    tmr_d     = TMR_W'(ETH_HDR_LEN - 1);
                    pay_cnt_d = '0;
                    trunc_d   = 1'b0;
                end
            end
            HDR: begin
                data_d   = hdr_sr[103:96];
                hdr_sr_d = {hdr_sr[95:0], 8'h00};
                valid_d  = 1'b1;
                crc_upd  = 1'b1;
                tmr_d    = tmr - TMR_W'(1);
                if (tmr == TMR_W'(1)) state_d = PAY;
            end
            PAY: begin
                valid_d = 1'b1;
                if (s_tvalid) begin
                    data_d    = s_tdata;
                    crc_upd   = 1'b1;
                    pay_cnt_d = pay_inc;
                    if (s_tlast) begin
                        if (pay_inc < PC_W'(ETH_MIN_PAYLOAD)) begin
                            state_d = PAD;
                            tmr_d   = TMR_W'(ETH_MIN_PAYLOAD) - TMR_W'(pay_inc);
                        end else begin
                            state_d = FCS;
                            tmr_d   = TMR_W'(ETH_FCS_LEN);
                        end
                    end else if (pay_inc == PC_W'(MAX_PAYLOAD)) begin
                        state_d     = FCS;
                        tmr_d       = TMR_W'(ETH_FCS_LEN);
                        trunc_d     = 1'b1;
                        trunc_cnt_d = trunc_cnt + CNT_W'(1);
                    end
                end else begin
                    // The MAC cannot stall: close the frame with a bad tail and no FCS
                    eof_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DROP;
                end
            end
            PAD: begin
                valid_d = 1'b1;
                crc_upd = 1'b1;
                tmr_d   = tmr - TMR_W'(1);
                if (tmr == TMR_W'(1)) begin
                    state_d = FCS;
                    tmr_d   = TMR_W'(ETH_FCS_LEN);
                end
            end
            FCS: begin
                valid_d = 1'b1;
                data_d  = ~crc[7:0];
                crc_d   = {8'h00, crc[31:8]};
                tmr_d   = tmr - TMR_W'(1);
                if (tmr == TMR_W'(1)) begin
                    eof_d       = 1'b1;
                    frame_cnt_d = frame_cnt + CNT_W'(1);
                    state_d     = trunc ? DROP : IFG;
                    tmr_d       = TMR_W'(IFG_CYCLES);
                end
            end
            DROP: begin
                crc_d = CRC32_INIT;
                if (s_tvalid && s_tlast) begin
                    state_d = IFG;
                    tmr_d   = TMR_W'(IFG_CYCLES);
                end
            end
            IFG: begin
                crc_d = CRC32_INIT;
                tmr_d = tmr - TMR_W'(1);
                if (tmr == TMR_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hdr_sr       <= '0;
            pay_cnt      <= '0;
            tmr          <= '0;
            trunc        <= 1'b0;
            crc          <= CRC32_INIT;
            mac_tx_data  <= '0;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            busy         <= 1'b0;
            tx_err       <= 1'b0;
            frame_cnt    <= '0;
            trunc_cnt    <= '0;
        end else begin
            state        <= state_d;
            hdr_sr       <= hdr_sr_d;
            pay_cnt      <= pay_cnt_d;
            tmr          <= tmr_d;
            trunc        <= trunc_d;
            crc          <= crc_upd ? crc_nxt : crc_d;
            mac_tx_data  <= data_d;
            mac_tx_valid <= valid_d;
            mac_tx_sof   <= sof_d;
            mac_tx_eof   <= eof_d;
            busy         <= (state_d != IDLE);
            tx_err       <= err_d;
            frame_cnt    <= frame_cnt_d;
            trunc_cnt    <= trunc_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected frame bytes are queued as stimulus is driven.
module tb_eth_tx_framer;

    localparam int MAXP = 1500;
    localparam int IFGC = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_valid, mac_tx_sof, mac_tx_eof, busy, tx_err;
    logic [15:0] frame_cnt, trunc_cnt;

    eth_tx_framer #(.MAX_PAYLOAD(MAXP), .IFG_CYCLES(IFGC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid), .mac_tx_sof(mac_tx_sof),
        .mac_tx_eof(mac_tx_eof), .busy(busy), .tx_err(tx_err),
        .frame_cnt(frame_cnt), .trunc_cnt(trunc_cnt)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] sb_q[$];   // {sof, eof, data}
    int sof_edge = 0, eof_edge = 0, last_gap = 0, flen = 0, last_len = 0, err_cnt = 0;
    int accept_edge = 0, drop_exit = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Golden FCS: MSB-first shift with polynomial 0x04C11DB7, data bits fed LSB first, result bit-reversed
    function automatic logic [31:0] fcs_model(input logic [7:0] f[$]);
        logic [31:0] n, r;
        logic        m;
        n = 32'hFFFFFFFF;
        foreach (f[i]) begin
            for (int b = 0; b < 8; b++) begin
                m = n[31] ^ f[i][b];
                n = {n[30:0], 1'b0};
                if (m) n = n ^ 32'h04C11DB7;
            end
        end
        n = ~n;
        for (int j = 0; j < 32; j++) r[j] = n[31-j];
        return r;
    endfunction

    // mode 0: normal, 1: underrun after `cut` bytes, 2: reset after `cut` bytes
    task automatic build_expected(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                                  input int len, input int seed, input int mode, input int cut);
        logic [7:0]  f[$];
        logic [31:0] fcs;
        int          np;
        for (int i = 0; i < 6; i++) f.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(s[47-8*i -: 8]);
        f.push_back(t[15:8]);
        f.push_back(t[7:0]);
        np = (mode != 0) ? cut : ((len > MAXP) ? MAXP : len);
        for (int i = 0; i < np; i++) f.push_back(8'((seed + i) & 255));
        if (mode == 0) begin
            while (f.size() < 60) f.push_back(8'h00);
            fcs = fcs_model(f);
            for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        end else if (mode == 1) begin
            f.push_back(8'h00);
        end
        foreach (f[i]) sb_q.push_back({(i == 0), (i == f.size() - 1) && (mode != 2), f[i]});
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        logic acc;
        s_tdata  = b;
        s_tlast  = last;
        s_tvalid = 1'b1;
        acc      = 1'b0;
        for (int w = 0; w < 4000 && !acc; w++) begin
            @(negedge clk);
            if (s_tready) acc = 1'b1;
        end
        if (!acc) begin
            check("accept_timeout", acc, 1);
            finish_test();
        end
        accept_edge = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int len, input int seed, input int mode, input int cut);
        build_expected(d, s, t, len, seed, mode, cut);
        dst_mac   = d;
        src_mac   = s;
        ethertype = t;
        for (int i = 0; i < len; i++) begin
            if (mode == 2 && i == cut) begin
                s_tvalid = 1'b0;
                return;
            end
            if (mode == 1 && i == cut) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            push_byte(8'((seed + i) & 255), (i == len - 1));
            if (i == 0) begin
                dst_mac   = ~d;
                src_mac   = ~s;
                ethertype = ~t;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 20000 && sb_q.size() != 0; w++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            finish_test();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_err) err_cnt++;
            if (mac_tx_valid) begin
                check("sb_pending", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) check("frame_byte", {mac_tx_sof, mac_tx_eof, mac_tx_data}, sb_q.pop_front());
                check("sof_and_eof", mac_tx_sof & mac_tx_eof, 0);
                if (mac_tx_sof) begin
                    last_gap = cyc - eof_edge - 1;
                    sof_edge = cyc;
                    flen     = 1;
                end else begin
                    flen++;
                end
                if (mac_tx_eof) begin
                    eof_edge = cyc;
                    last_len = flen;
                end
            end else if (mac_tx_sof || mac_tx_eof) begin
                check("flag_without_valid", {mac_tx_sof, mac_tx_eof}, 0);
            end
        end
    end

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        dst_mac = '0; src_mac = '0; ethertype = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_data, busy, tx_err, s_tready}, 0);
        check("reset_counters", {frame_cnt, trunc_cnt}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 100, 0, 0, 0);
        wait_drain();
        check("len_100", last_len, 118);
        check("frame_cnt_1", frame_cnt, 1);

        send_frame(48'h0A0B0C0D0E0F, 48'h020000000001, 16'h86DD, 1, 8'hAB, 0, 0);
        wait_drain();
        check("len_min", last_len, 64);
        check("frame_cnt_2", frame_cnt, 2);
        check("busy_in_ifg", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        check("busy_idle", busy, 0);

        send_frame(48'h112233445566, 48'h665544332211, 16'h0800, 1600, 7, 0, 0);
        drop_exit = accept_edge;
        wait_drain();
        check("len_trunc", last_len, 1518);
        check("trunc_cnt_1", trunc_cnt, 1);
        check("frame_cnt_3", frame_cnt, 3);

        send_frame(48'h001122334455, 48'h020000000002, 16'h0806, 60, 8'h30, 1, 20);
        wait_drain();
        check("ifg_after_drop", (sof_edge - drop_exit >= IFGC + 1), 1);
        check("len_underrun", last_len, 35);
        check("tx_err_pulses", err_cnt, 1);
        check("frame_cnt_underrun", frame_cnt, 3);
        repeat (20) @(posedge clk);
        #1;
        check("busy_after_drop", busy, 0);

        send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 46, 1, 0, 0);
        send_frame(48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6, 16'h0800, 46, 2, 0, 0);
        wait_drain();
        check("b2b_gap", last_gap, IFGC);
        check("len_46", last_len, 64);
        check("frame_cnt_5", frame_cnt, 5);

        send_frame(48'h0F0E0D0C0B0A, 48'h020000000003, 16'h0800, 60, 9, 2, 30);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", {mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_data, busy, tx_err, frame_cnt, trunc_cnt}, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_frame(48'h5A5A5A5A5A5A, 48'h020000000004, 16'h88B5, 100, 8'h55, 0, 0);
        wait_drain();
        check("len_after_reset", last_len, 118);
        check("frame_cnt_after_reset", frame_cnt, 1);
        repeat (20) @(posedge clk);
        finish_test();
    end

endmodule
